// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers, cancel and mthi/mtlo writes.
module mdu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [2:0] MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q, q_s, r_s, q_u, r_u;
  logic [2*WIDTH-1:0] prod_s, prod_u, res;
  logic div0, ovf;
  assign busy = cnt != '0;
  // Result is formed from latched operands; it is only sampled on the final busy edge.
  always_comb begin
    prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    q_s = $signed(a_q) / $signed(b_q);
    r_s = $signed(a_q) % $signed(b_q);
    q_u = a_q / b_q;
    r_u = a_q % b_q;
    div0 = b_q == '0;
    ovf = op_q == DIV && a_q == {1'b1, {(WIDTH-1){1'b0}}} && b_q == '1;
    res = op_q == MULT  ? prod_s :
          op_q == MULTU ? prod_u :
          div0          ? {a_q, {WIDTH{1'b1}}} :
          ovf           ? {{WIDTH{1'b0}}, a_q} :
          op_q == DIV   ? {r_s, q_s} : {r_u, q_u};
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (cancel) cnt <= '0;
        else begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            done <= 1'b1;
            {hi, lo} <= res;
          end
        end
      end else if (start && !cancel) begin
        if (op == MTHI) hi <= rs;
        if (op == MTLO) lo <= rs;
        if (op >= MULT && op <= DIVU) begin
          op_q <= op;
          a_q <= rs;
          b_q <= rt;
          cnt <= op <= MULTU ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, cancel = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] rs = '0, rt = '0, hi, lo;
  logic busy, done, done_seen;
  int checks = 0, errors = 0;
  mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .rs(rs), .rt(rt),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Caller is at a negedge; start is driven immediately so back-to-back calls have no gap.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    start = 1'b1; op = o; rs = a; rt = b;
    @(negedge clk);
    start = 1'b0; rs = $urandom; rt = $urandom;
    chk({tag, " accept"}, {62'b0, busy, done}, 64'd2);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      chk({tag, " busy"}, {62'b0, busy, done}, 64'd2);
    end
    @(negedge clk);
    chk({tag, " done"}, {62'b0, busy, done}, 64'd1);
    chk({tag, " hilo"}, {hi, lo}, {eh, el});
  endtask
  task automatic mv(input logic [2:0] o, input logic [31:0] v);
    start = 1'b1; op = o; rs = v;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    #1;
    chk("reset ctl", {62'b0, busy, done}, 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE, "mult");
    run_op(3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
    run_op(3'd3, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
    run_op(3'd4, 32'h7, 32'h0, 10, 32'h7, 32'hFFFFFFFF, "divu0");
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, "divovf");
    run_op(3'd3, 32'h7, 32'hFFFFFFFE, 10, 32'h1, 32'hFFFFFFFD, "divneg");
    run_op(3'd3, 32'hFFFFFFFB, 32'h0, 10, 32'hFFFFFFFB, 32'hFFFFFFFF, "div0");
    run_op(3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu");
    mv(3'd5, 32'h1234);
    chk("mthi hilo", {hi, lo}, {32'h1234, 32'd14});
    chk("mthi ctl", {62'b0, busy, done}, 64'd0);
    mv(3'd6, 32'h5678);
    chk("mtlo hilo", {hi, lo}, {32'h1234, 32'h5678});
    start = 1'b1; op = 3'd0; rs = 32'hDEAD;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    op = 3'd5; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("ignored hilo", {hi, lo}, {32'h1234, 32'h5678});
    chk("ignored ctl", {62'b0, busy, done}, 64'd0);
    start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd4;
    @(negedge clk);
    op = 3'd6; rs = 32'hDEAD;
    @(negedge clk);
    op = 3'd4; rs = 32'd9; rt = 32'd3;
    @(negedge clk);
    start = 1'b0;
    chk("busy ign lo", {32'b0, lo}, {32'b0, 32'h5678});
    repeat (2) @(negedge clk);
    chk("busy ign run", {62'b0, busy, done}, 64'd2);
    @(negedge clk);
    chk("busy ign done", {62'b0, busy, done}, 64'd1);
    chk("busy ign hilo", {hi, lo}, {32'd0, 32'd12});
    mv(3'd5, 32'hA5A5A5A5);
    mv(3'd6, 32'hA5A5A5A5);
    chk("a5 hilo", {hi, lo}, {2{32'hA5A5A5A5}});
    start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel3 ctl", {62'b0, busy, done}, 64'd0);
    chk("cancel3 hilo", {hi, lo}, {2{32'hA5A5A5A5}});
    @(negedge clk);
    chk("cancel3 after", {62'b0, busy, done}, 64'd0);
    start = 1'b1; op = 3'd1; rs = 32'd3; rt = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("cancelN run", {62'b0, busy, done}, 64'd2);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancelN ctl", {62'b0, busy, done}, 64'd0);
    chk("cancelN hilo", {hi, lo}, {2{32'hA5A5A5A5}});
    @(negedge clk);
    chk("cancelN after", {62'b0, busy, done}, 64'd0);
    start = 1'b1; op = 3'd3; rs = 32'd100; rt = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async rst ctl", {62'b0, busy, done}, 64'd0);
    chk("async rst hilo", {hi, lo}, 64'd0);
    #1 reset_n = 1'b1;
    done_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      done_seen |= done;
    end
    chk("no late done", {63'b0, done_seen}, 64'd0);
    chk("no late hilo", {hi, lo}, 64'd0);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    mv(3'd5, 32'd77);
    chk("first edge", {hi, lo}, {32'd77, 32'd0});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width (>=8).
REQ-002 SHALL have parameter MULT_CYCLES, default 5, multiply latency in cycles (>=1).
REQ-003 SHALL have parameter DIV_CYCLES, default 10, divide latency in cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request strobe, sampled each rising edge.
REQ-007 SHALL have port op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none.
REQ-008 SHALL have port rs  input  WIDTH  operand A / dividend / mthi-mtlo source.
REQ-009 SHALL have port rt  input  WIDTH  operand B / divisor.
REQ-010 SHALL have port cancel  input  1  abort in-flight operation (exception flush).
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have port done  output  1  one-cycle pulse, HI/LO just committed by mult/div.
REQ-013 SHALL have port hi  output  WIDTH  HI register, direct register output.
REQ-014 SHALL have port lo  output  WIDTH  LO register, direct register output.

Function
REQ-015 SHALL accept a request only on an edge where start=1, busy=0, cancel=0, op in 1..6; all other start edges ignored, no state change.
REQ-016 SHALL write rs into HI (op 5) or LO (op 6) at the accepting edge; busy and done unaffected.
REQ-017 SHALL, on accepted op 1-4, latch rs/rt and op, load a down-counter with MULT_CYCLES or DIV_CYCLES, assert busy from that edge.
REQ-018 SHALL hold busy high for exactly the latency N cycles; at edge N after acceptance, commit HI/LO, clear busy, set done for one cycle.
REQ-019 SHALL allow a new request on the cycle following completion (busy=0), back-to-back without a gap cycle.
REQ-020 SHALL compute mult as signed WIDTHxWIDTH -> 2*WIDTH product, HI=upper WIDTH, LO=lower WIDTH; multu identically but unsigned.
REQ-021 SHALL compute div signed, quotient truncated toward zero into LO, remainder (sign of dividend) into HI; divu unsigned.
REQ-022 SHALL on divisor zero (div or divu) set LO=all ones, HI=rs.
REQ-023 SHALL on signed overflow (rs=most-negative, rt=all ones) set LO=rs, HI=0.
REQ-024 SHALL use the operands latched at acceptance; rs/rt changes while busy have no effect.
REQ-025 SHALL on cancel=1 while busy, at that edge clear busy, leave HI/LO at pre-request values, suppress done.
REQ-026 SHALL give cancel priority over completion when both fall on the same edge (no commit, no done).
REQ-027 SHALL ignore cancel when busy=0.
REQ-028 SHALL keep HI/LO unchanged between commits and writes.

Reset
REQ-029 SHALL on reset_n=0 immediately force busy=0, done=0, hi=0, lo=0, counter=0, regardless of clk.
REQ-030 SHALL abandon any in-flight operation on reset; no commit after reset_n returns high.
REQ-031 SHALL accept a request on the first rising edge with reset_n=1.

Verification (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10)
REQ-032 SHALL cover mult rs=0xFFFFFFFF rt=0x2 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE, done one cycle; multu same -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-033 SHALL cover div rs=0xFFFFFFF9 rt=0x2 -> after 10 cycles LO=0xFFFFFFFD HI=0xFFFFFFFF; divu rs=0x7 rt=0 -> LO=0xFFFFFFFF HI=0x7.
REQ-034 SHALL cover div rs=0x80000000 rt=0xFFFFFFFF -> LO=0x80000000 HI=0x00000000.
REQ-035 SHALL cover mthi rs=0x1234 while idle -> HI=0x1234 next edge, busy stays 0; mtlo and mult start during busy -> ignored, original result commits unchanged.
REQ-036 SHALL cover HI=LO=0xA5A5A5A5, mult started, cancel at busy cycle 3 -> busy 0 next edge, HI/LO stay 0xA5A5A5A5, no done; cancel on final cycle -> same.
REQ-037 SHALL cover reset_n pulsed low mid-div (between edges) -> busy, done, hi, lo read 0 before next edge; no late commit.
